// File: rtl/ypc_pkg.sv
// Shared writeback types: source identifiers, default entry layout and the
// x0 register index.
package ypc_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned REG_ZERO  = 0;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                 wen;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and register-file-side signals of the writeback stage.
// The slave modport is the arbiter; the master modport is whoever drives it.
interface wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) ();
    logic                  exu_valid;
    logic                  exu_ready;
    logic                  exu_wen;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  retire_valid;
    logic [CNT_WIDTH-1:0]  retire_cnt;

    modport slave (
        input  exu_valid, exu_wen, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output exu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, retire_valid, retire_cnt
    );

    modport master (
        output exu_valid, exu_wen, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  exu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, retire_valid, retire_cnt
    );
endinterface

// File: rtl/wb_slot.sv
// One-entry holding buffer. Ready depends only on occupancy and the drain
// request, so a drain and a refill can happen in the same cycle.
module wb_slot
    import ypc_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    output logic   o_ready,
    input  entry_t i_data,
    input  logic   i_drain,
    output logic   o_full,
    output entry_t o_data
);
    logic   r_full;
    entry_t r_data;

    assign o_ready = !r_full || i_drain;
    assign o_full  = r_full;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: two holding slots (EXU, LSU), round-robin pick on conflict,
// registered register-file write port and a wrapping retire counter.
module wb_arbiter
    import ypc_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic                  wen;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [1:0] w_in_valid;
    logic [1:0] w_ready;
    logic [1:0] w_full;
    logic [1:0] w_gnt;
    logic       w_conflict;
    logic       w_gnt_any;
    entry_t     w_in_entry [2];
    entry_t     w_out      [2];
    entry_t     w_sel_entry;

    wb_src_e               r_rr_ptr;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_retire_valid;
    logic [CNT_WIDTH-1:0]  r_retire_cnt;

    assign w_in_valid[WB_EXU] = bus.exu_valid;
    assign w_in_valid[WB_LSU] = bus.lsu_valid;
    assign w_in_entry[WB_EXU] = '{wen: bus.exu_wen, rd: bus.exu_rd, data: bus.exu_data};
    // Loads always write their destination.
    assign w_in_entry[WB_LSU] = '{wen: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            wb_slot #(.entry_t(entry_t)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_valid (w_in_valid[gi]),
                .o_ready (w_ready[gi]),
                .i_data  (w_in_entry[gi]),
                .i_drain (w_gnt[gi]),
                .o_full  (w_full[gi]),
                .o_data  (w_out[gi])
            );
        end
    endgenerate

    assign bus.exu_ready = w_ready[WB_EXU];
    assign bus.lsu_ready = w_ready[WB_LSU];

    // Grant looks only at slot occupancy, keeping ready free of any valid path.
    always_comb begin
        w_gnt      = 2'b00;
        w_conflict = w_full[WB_EXU] && w_full[WB_LSU];
        if (w_conflict) begin
            w_gnt = (r_rr_ptr == WB_EXU) ? 2'b01 : 2'b10;
        end else begin
            w_gnt = w_full;
        end
    end

    assign w_gnt_any   = |w_gnt;
    assign w_sel_entry = w_gnt[WB_LSU] ? w_out[WB_LSU] : w_out[WB_EXU];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= WB_EXU;
            r_rf_wen       <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_retire_valid <= 1'b0;
            r_retire_cnt   <= '0;
        end else begin
            if (w_conflict) begin
                r_rr_ptr <= (r_rr_ptr == WB_EXU) ? WB_LSU : WB_EXU;
            end
            r_rf_wen <= w_gnt_any && w_sel_entry.wen
                        && (w_sel_entry.rd != ADDR_WIDTH'(REG_ZERO));
            if (w_gnt_any) begin
                r_rf_waddr <= w_sel_entry.rd;
                r_rf_wdata <= w_sel_entry.data;
            end
            r_retire_valid <= w_gnt_any;
            r_retire_cnt   <= r_retire_cnt + CNT_WIDTH'(w_gnt_any);
        end
    end

    assign bus.rf_wen       = r_rf_wen;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.retire_valid = r_retire_valid;
    assign bus.retire_cnt   = r_retire_cnt;
endmodule
